pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the accumulator processor's fetch stage. It is the consumer end of the IR left-shift path: it takes the 14-bit word-aligned jump target (IR immediate << 1) and turns it into the next fetch address. It also handles sequential increment, conditional branches, and call/return through a small hardware return-address stack. It sits between the control FSM, which supplies the op and write enable, and instruction memory, which is driven by PC.

## Interface
- `PC_WIDTH`, 16, fetch address width (byte address; instructions are 16-bit).
- `RESET_VECTOR`, 16'h0000, PC value after reset; bit 0 must be 0.
- `STACK_DEPTH`, 4, return-address stack entries (power of 2, 2..8).
- `CLK` input 1: system clock, rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `PCWrite` input 1: when 1, `Op` is executed at this edge; when 0, all state holds.
- `Op` input 3: 000 NEXT, 001 JUMP, 010 CALL, 011 RET, 100 BRANCH, 101–111 HOLD.
- `Cond` input 1: branch condition; used only by BRANCH.
- `Target` input 14: jump target, already shifted (bit 0 = 0).
- `PC` output PC_WIDTH: current fetch address.
- `PCPlus2` output PC_WIDTH: combinational PC + 2, mod 2^PC_WIDTH.
- `Depth` output 4: number of valid stack entries.
- `StackFull` output 1: Depth == STACK_DEPTH.
- `StackEmpty` output 1: Depth == 0.
- `StackErr` output 1: sticky flag for overflow or underflow.

## Operation
- Jump address is pseudo-direct: `JA = {PC[PC_WIDTH-1:14], Target[13:1], 1'b0}`. Target bit 0 is ignored and forced to 0.
- Every op below applies only when `PCWrite`=1:
  - NEXT: PC ← PCPlus2.
  - JUMP: PC ← JA.
  - CALL: if not full, push PCPlus2, Depth+1, PC ← JA. If full, no push and PC ← PCPlus2 (the call is skipped), and StackErr ← 1.
  - RET: if not empty, PC ← top entry, Depth−1. If empty, PC ← PCPlus2 and StackErr ← 1.
  - BRANCH: PC ← JA if Cond=1, else PCPlus2.
  - HOLD (101–111): no state change.
- The stack is LIFO, implemented as a register array with a pointer. Entries beyond Depth are don't-care. A pop returns the most recent push.
- StackErr clears only on reset.
- PC bit 0 is always 0.
- PC increment wraps: 16'hFFFE + 2 → 16'h0000. JA never carries into the upper PC bits.

## Timing
- Reset (asynchronous, `Reset_n`=0) takes effect immediately and holds while low:
  - PC = RESET_VECTOR.
  - Depth = 0, StackEmpty = 1, StackFull = 0, StackErr = 0.
  - PCPlus2 = RESET_VECTOR + 2.
- Reset mid-operation discards all stack contents and any op at that edge.
- Single-cycle latency: the op is sampled at rising CLK with PCWrite=1. The new PC, Depth and flags are visible right after that edge.
- PCPlus2, StackFull and StackEmpty are combinational from registered state. Each op pushes or pops at most once per cycle.
- PCWrite=0 with any Op value: PC, stack, Depth and StackErr are all unchanged.
- CALL then RET on consecutive cycles returns the CALL's PC+2. The RET reads the entry written at the previous edge; no bypass is needed.
- Inputs must be stable around the rising edge. `Cond` and `Target` are don't-care for ops that do not use them.

## Test plan
- Reset/NEXT: hold Reset_n=0, then release. PC=0000, StackEmpty=1. Three NEXT cycles → PC=0002, 0004, 0006. PCWrite=0 for 2 cycles → PC stays 0006.
- JUMP/BRANCH: at PC=0006, JUMP Target=14'h3FFE → PC=3FFE. BRANCH Cond=0 → PC=4000. BRANCH Cond=1, Target=0010 → PC=4010 (upper bits kept).
- CALL/RET nesting: from PC=0100, CALL 0200 then CALL 0300 → Depth=2, PC=0300. RET → PC=0202. RET → PC=0102, Depth=0.
- Overflow: perform 4 CALLs to 0040 (PC=0040 after each) → StackFull=1. A 5th CALL at PC=0040 → PC=0042, Depth stays 4, StackErr=1.
- Underflow: from empty at PC=0500, RET → PC=0502 and StackErr=1. StackErr stays 1 through 10 NEXT cycles.
- Async reset/wrap: set PC=FFFE, NEXT → 0000. With Depth=2, assert Reset_n mid-cycle → PC=RESET_VECTOR, Depth=0, StackErr=0 before the next CLK edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential, pseudo-direct jump,
// branch, and call/return through a small return-address stack.
//
// Ports:
//   CLK, Reset_n    clock (rising edge), async active-low reset
//   PCWrite, Op     execute Op at this edge when PCWrite=1
//   Cond, Target    branch condition, pre-shifted 14-bit target
//   PC, PCPlus2     current fetch address and its successor
//   Depth           valid return-stack entries
//   StackFull/Empty stack occupancy flags
//   StackErr        sticky overflow/underflow flag
module pc_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                Reset_n,
  input  logic                PCWrite,
  input  logic [2:0]          Op,
  input  logic                Cond,
  input  logic [13:0]         Target,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlus2,
  output logic [3:0]          Depth,
  output logic                StackFull,
  output logic                StackEmpty,
  output logic                StackErr
);

  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [3:0] FULL_D = 4'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT   = 3'b000,
    OP_JUMP   = 3'b001,
    OP_CALL   = 3'b010,
    OP_RET    = 3'b011,
    OP_BRANCH = 3'b100
  } op_e;

  logic [PC_WIDTH-1:0] pcReg;
  logic [PC_WIDTH-1:0] pcNext;
  logic [PC_WIDTH-1:0] ja;
  logic [3:0]          depthReg;
  logic [3:0]          depthNext;
  logic                errReg;
  logic                errNext;
  logic                push;
  logic [SP_W-1:0]     pushIdx;
  logic [SP_W-1:0]     topIdx;
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

  assign PCPlus2    = pcReg + PC_WIDTH'(2);
  assign StackFull  = (depthReg == FULL_D);
  assign StackEmpty = (depthReg == 4'd0);
  assign PC         = pcReg;
  assign Depth      = depthReg;
  assign StackErr   = errReg;

  // Target[0] is masked rather than dropped so the
  // jump address is always halfword aligned.
  assign ja = {pcReg[PC_WIDTH-1:14], Target[13:1],
               Target[0] & 1'b0};

  assign pushIdx = depthReg[SP_W-1:0];
  assign topIdx  = SP_W'(depthReg - 4'd1);

  always_comb begin
    pcNext    = pcReg;
    depthNext = depthReg;
    errNext   = errReg;
    push      = 1'b0;
    if (PCWrite) begin
      case (Op)
        OP_NEXT: pcNext = PCPlus2;
        OP_JUMP: pcNext = ja;
        OP_CALL: begin
          if (!StackFull) begin
            push      = 1'b1;
            depthNext = depthReg + 4'd1;
            pcNext    = ja;
          end else begin
            pcNext  = PCPlus2;
            errNext = 1'b1;
          end
        end
        OP_RET: begin
          if (!StackEmpty) begin
            depthNext = depthReg - 4'd1;
            pcNext    = stack[topIdx];
          end else begin
            pcNext  = PCPlus2;
            errNext = 1'b1;
          end
        end
        OP_BRANCH: pcNext = Cond ? ja : PCPlus2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pcReg    <= RESET_VECTOR;
      depthReg <= '0;
      errReg   <= 1'b0;
    end else begin
      pcReg    <= pcNext;
      depthReg <= depthNext;
      errReg   <= errNext;
    end
  end

  // Entries at or above Depth are dead, so the array
  // needs no reset.
  always_ff @(posedge CLK) begin
    if (push) stack[pushIdx] <= PCPlus2;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_pc_sequencer;

  logic        CLK;
  logic        Reset_n;
  logic        PCWrite;
  logic [2:0]  Op;
  logic        Cond;
  logic [13:0] Target;
  logic [15:0] PC;
  logic [15:0] PCPlus2;
  logic [3:0]  Depth;
  logic        StackFull;
  logic        StackEmpty;
  logic        StackErr;

  int checks = 0;
  int failures = 0;

  pc_sequencer dut (
    .CLK(CLK), .Reset_n(Reset_n), .PCWrite(PCWrite),
    .Op(Op), .Cond(Cond), .Target(Target),
    .PC(PC), .PCPlus2(PCPlus2), .Depth(Depth),
    .StackFull(StackFull), .StackEmpty(StackEmpty),
    .StackErr(StackErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [2:0] NXT = 3'd0;
  localparam logic [2:0] JMP = 3'd1;
  localparam logic [2:0] CAL = 3'd2;
  localparam logic [2:0] RET = 3'd3;
  localparam logic [2:0] BRA = 3'd4;

  // Reference model: PC as a plain number, stack as a queue.
  logic [15:0] mPc = 16'h0000;
  logic [15:0] mStk [$];
  logic        mErr = 1'b0;
  logic [15:0] mJa;
  logic [15:0] mNx;

  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      mPc = 16'h0000;
      mStk.delete();
      mErr = 1'b0;
    end else if (PCWrite) begin
      mJa = (mPc & 16'hC000) | {2'b00, Target & 14'h3FFE};
      mNx = mPc + 16'd2;
      if (Op == NXT) mPc = mNx;
      else if (Op == JMP) mPc = mJa;
      else if (Op == CAL) begin
        if (mStk.size() < 4) begin
          mStk.push_back(mNx);
          mPc = mJa;
        end else begin
          mPc = mNx;
          mErr = 1'b1;
        end
      end else if (Op == RET) begin
        if (mStk.size() > 0) mPc = mStk.pop_back();
        else begin
          mPc = mNx;
          mErr = 1'b1;
        end
      end else if (Op == BRA) mPc = Cond ? mJa : mNx;
    end
  end

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    check("m_pc", PC, mPc);
    check("m_pcPlus2", PCPlus2, mPc + 16'd2);
    check("m_depth", {12'd0, Depth}, 16'(mStk.size()));
    check("m_full", {15'd0, StackFull},
          {15'd0, mStk.size() == 4});
    check("m_empty", {15'd0, StackEmpty},
          {15'd0, mStk.size() == 0});
    check("m_err", {15'd0, StackErr}, {15'd0, mErr});
  end

  task automatic doOp(input logic [2:0] op,
                      input logic c,
                      input logic [13:0] t);
    PCWrite = 1'b1;
    Op = op;
    Cond = c;
    Target = t;
    @(posedge CLK);
    #2;
    PCWrite = 1'b0;
    Op = NXT;
  endtask

  task automatic idle(input logic [2:0] op);
    PCWrite = 1'b0;
    Op = op;
    Target = 14'h1234;
    @(posedge CLK);
    #2;
  endtask

  task automatic pulseReset();
    PCWrite = 1'b0;
    Reset_n = 1'b0;
    @(posedge CLK);
    #2;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b0;
    PCWrite = 1'b0;
    Op = NXT;
    Cond = 1'b0;
    Target = 14'h0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("rst_pc", PC, 16'h0000);
    check("rst_pc2", PCPlus2, 16'h0002);
    check("rst_empty", {15'd0, StackEmpty}, 16'd1);
    check("rst_full", {15'd0, StackFull}, 16'd0);
    check("rst_depth", {12'd0, Depth}, 16'd0);
    check("rst_err", {15'd0, StackErr}, 16'd0);
    Reset_n = 1'b1;

    doOp(NXT, 0, 0); check("next1", PC, 16'h0002);
    doOp(NXT, 0, 0); check("next2", PC, 16'h0004);
    doOp(NXT, 0, 0); check("next3", PC, 16'h0006);
    idle(JMP);
    idle(CAL);
    check("hold_pcw0", PC, 16'h0006);

    doOp(JMP, 0, 14'h3FFE); check("jump", PC, 16'h3FFE);
    doOp(BRA, 0, 14'h0100); check("br_nt", PC, 16'h4000);
    doOp(BRA, 1, 14'h0010); check("br_t", PC, 16'h4010);
    doOp(JMP, 0, 14'h0101); check("jmp_b0", PC, 16'h4100);

    pulseReset();
    doOp(JMP, 0, 14'h0100); check("jmp100", PC, 16'h0100);
    doOp(CAL, 0, 14'h0200); check("call1", PC, 16'h0200);
    doOp(CAL, 0, 14'h0300); check("call2", PC, 16'h0300);
    check("call_d2", {12'd0, Depth}, 16'd2);
    doOp(RET, 0, 0); check("ret1", PC, 16'h0202);
    doOp(RET, 0, 0); check("ret2", PC, 16'h0102);
    check("ret_d0", {12'd0, Depth}, 16'd0);
    doOp(3'b110, 1, 14'h0222); check("hold_op", PC, 16'h0102);

    doOp(JMP, 0, 14'h0040);
    for (int i = 0; i < 4; i++) begin
      doOp(CAL, 0, 14'h0040);
      check("ovf_call", PC, 16'h0040);
    end
    check("ovf_full", {15'd0, StackFull}, 16'd1);
    check("ovf_err0", {15'd0, StackErr}, 16'd0);
    doOp(CAL, 0, 14'h0040);
    check("ovf_pc", PC, 16'h0042);
    check("ovf_d4", {12'd0, Depth}, 16'd4);
    check("ovf_err", {15'd0, StackErr}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      doOp(RET, 0, 0);
      check("ovf_ret", PC, 16'h0042);
    end
    check("ovf_empty", {15'd0, StackEmpty}, 16'd1);

    pulseReset();
    check("rst2_err", {15'd0, StackErr}, 16'd0);
    doOp(JMP, 0, 14'h0500);
    doOp(RET, 0, 0);
    check("unf_pc", PC, 16'h0502);
    check("unf_err", {15'd0, StackErr}, 16'd1);
    for (int i = 0; i < 10; i++) doOp(NXT, 0, 0);
    check("unf_pc10", PC, 16'h0516);
    check("unf_sticky", {15'd0, StackErr}, 16'd1);

    for (int i = 0; i < 3; i++) begin
      doOp(JMP, 0, 14'h3FFE);
      doOp(NXT, 0, 0);
    end
    check("climb", PC, 16'hC000);
    doOp(JMP, 0, 14'h3FFE);
    check("top_pc", PC, 16'hFFFE);
    check("top_pc2", PCPlus2, 16'h0000);
    doOp(NXT, 0, 0);
    check("wrap", PC, 16'h0000);
    doOp(CAL, 0, 14'h0010);
    doOp(CAL, 0, 14'h0010);
    check("pre_d2", {12'd0, Depth}, 16'd2);

    @(negedge CLK);
    #1 Reset_n = 1'b0;
    #1;
    check("ar_pc", PC, 16'h0000);
    check("ar_depth", {12'd0, Depth}, 16'd0);
    check("ar_err", {15'd0, StackErr}, 16'd0);
    check("ar_empty", {15'd0, StackEmpty}, 16'd1);
    @(posedge CLK);
    #2 Reset_n = 1'b1;

    doOp(CAL, 0, 14'h0020); check("bb_call", PC, 16'h0020);
    doOp(RET, 0, 0); check("bb_ret", PC, 16'h0002);

    @(posedge CLK);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
